simplebus_leader_engine: RTL and testbench
==========================================

Name: simplebus_leader_engine

Overview:
- Synthesizable leader for the simplebus protocol. Replaces task-driven processor stimulus with a real initiator.
- Accepts read/write commands from a host-side valid/ready port and buffers them in a FIFO. Runs each command on the bus against any simplebus follower, such as the memory follower.
- Returns one response per command. Includes a read timeout so a silent follower cannot hang the host.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2).
- TIMEOUT, 16, max RD_WAIT cycles before a read is aborted (≥2).

Ports:
- clock  input  1  single clock, all state on posedge.
- resetN  input  1  asynchronous, active-low reset.
- bus  interface  simplebus.leader  start/read/address/data/dataValid (tri).
- req_valid  input  1  host command valid.
- req_ready  output  1  FIFO can accept this cycle.
- req_write  input  1  1=write, 0=read.
- req_addr  input  16  target address.
- req_wdata  input  8  write data (ignored for reads).
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  8  read data (0 for writes/errors).
- rsp_err  output  1  1 = read timed out.

Behaviour:
- Reset (async, resetN=0):
  - State=IDLE, FIFO empty, timeout counter 0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1.
  - bus.start=0, bus.read=0; bus.address, bus.data, bus.dataValid = 'z.
  - Reset mid-transaction aborts it immediately, releases the bus, discards the FIFO, and emits no response.
- FIFO:
  - Push when req_valid && req_ready.
  - req_ready = !full, from the registered count only. A pop in the same cycle does not allow a push when full.
  - Simultaneous push and pop when not full leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, ADDR_LO, RD_WAIT, WR_DATA.
  - IDLE:
    - If FIFO non-empty: drive bus.start=1 and bus.address=head.addr[15:8]. At the edge, pop the head into the current-command regs and go to ADDR_LO.
    - Else: start=0, address='z.
  - ADDR_LO:
    - Drive bus.address=cur.addr[7:0] and bus.read=!cur.write.
    - Next state is RD_WAIT for a read, WR_DATA for a write. Always exactly one cycle.
  - WR_DATA:
    - Drive bus.data=cur.wdata and bus.dataValid=1 for exactly one cycle, then go to IDLE.
    - Next edge: rsp_valid=1, rsp_err=0, rsp_rdata=0.
  - RD_WAIT:
    - Leader does not drive data or dataValid (follower drives them). Sample bus.dataValid each edge.
    - If dataValid=1: capture bus.data. Next cycle rsp_valid=1, rsp_rdata=captured, rsp_err=0. Go to IDLE.
    - Else increment the counter. When the counter reaches TIMEOUT-1 with no dataValid: go to IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0, counter cleared.
    - dataValid on the same edge as the timeout counts as success.
- Outside these windows:
  - start and read = 0.
  - address = 'z except IDLE-with-start and ADDR_LO.
  - data and dataValid = 'z except WR_DATA.
- Timing:
  - Write latency, push edge to rsp_valid: 4 cycles (FIFO, IDLE/start, ADDR_LO, WR_DATA, rsp).
  - Read latency: 4 + follower wait cycles.
  - Back-to-back: the next start is asserted in the IDLE cycle immediately after completion, so one bus transaction per 3 cycles for writes.
- Responses:
  - In command order, exactly one per command. rsp_valid is a registered single-cycle pulse with no backpressure.

Test Plan:
- Write 0x0406←0xDC, then read 0x0406 against the memory follower.
  - start in cycle 1, address 0x04 then 0x06, write rsp at +4.
  - Read rsp_rdata=0xDC, rsp_err=0.
- Push 4 writes back-to-back (0x0010..0x0013 ← 0xA0..0xA3) with FIFO_DEPTH=4.
  - req_ready stays 1 until full.
  - Starts occur every 3 cycles.
  - Four rsp pulses in order; read-back returns 0xA0..0xA3.
- Hold req_valid with 6 queued commands.
  - req_ready deasserts when count=4.
  - A push and pop on the same full cycle accepts nothing.
  - All 6 complete in order.
- Follower never asserts dataValid on a read of 0x1234, TIMEOUT=16.
  - rsp_valid with rsp_err=1, rsp_rdata=0, exactly 16 cycles after entering RD_WAIT.
  - The next queued write proceeds normally.
- Follower delays dataValid by 15 RD_WAIT cycles (the boundary).
  - Succeeds with rsp_err=0 and correct data.
- Assert resetN=0 mid RD_WAIT with 2 commands queued.
  - Bus lines go 'z/0 asynchronously and no rsp_valid pulses.
  - After release: req_ready=1, FIFO empty, state IDLE.

Source files
------------

// File: rtl/simplebus_leader_engine_if.sv
// simplebus: one leader drives start/read/address; data and dataValid are shared
// tri-state lines that the leader owns for writes and the follower owns for reads.
interface simplebus;
  logic       start;
  logic       read;
  tri   [7:0] address;
  tri   [7:0] data;
  tri         dataValid;

  modport leader (
    output start,
    output read,
    inout  address,
    inout  data,
    inout  dataValid
  );

  modport follower (
    input  start,
    input  read,
    input  address,
    inout  data,
    inout  dataValid
  );
endinterface

// File: rtl/simplebus_leader_engine.sv
// simplebus_leader_engine: queues host read/write commands in a FIFO and runs each
// one on simplebus as the initiator, returning exactly one response per command.
module simplebus_leader_engine #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clock,
  input  logic        resetN,
  simplebus.leader    bus,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ADDR_LO, RD_WAIT, WR_DATA} state_t;

  state_t            state;
  logic [15:0]       fifo_addr  [FIFO_DEPTH];
  logic              fifo_write [FIFO_DEPTH];
  logic [7:0]        fifo_wdata [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  logic [15:0]       cur_addr;
  logic              cur_write;
  logic [7:0]        cur_wdata;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              addr_en;
  logic [7:0]        addr_val;

  // Ready comes only from the registered count, so a pop never frees a slot early.
  assign req_ready = (count != FULL_COUNT);
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (count != '0);

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= req_addr;
      fifo_write[wr_ptr] <= req_write;
      fifo_wdata[wr_ptr] <= req_wdata;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      cur_addr  <= '0;
      cur_write <= 1'b0;
      cur_wdata <= '0;
      tmo_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            cur_addr  <= fifo_addr[rd_ptr];
            cur_write <= fifo_write[rd_ptr];
            cur_wdata <= fifo_wdata[rd_ptr];
            state     <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          tmo_cnt <= '0;
          state   <= cur_write ? WR_DATA : RD_WAIT;
        end
        WR_DATA: begin
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        RD_WAIT: begin
          // Data arriving on the final allowed cycle still wins over the timeout.
          if (bus.dataValid == 1'b1) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= bus.data;
            tmo_cnt   <= '0;
            state     <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            tmo_cnt   <= '0;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    addr_en  = 1'b0;
    addr_val = 8'h00;
    if (pop) begin
      addr_en  = 1'b1;
      addr_val = fifo_addr[rd_ptr][15:8];
    end else if (state == ADDR_LO) begin
      addr_en  = 1'b1;
      addr_val = cur_addr[7:0];
    end
  end

  assign bus.start     = pop;
  assign bus.read      = (state == ADDR_LO) && !cur_write;
  assign bus.address   = addr_en ? addr_val : 8'bz;
  assign bus.data      = (state == WR_DATA) ? cur_wdata : 8'bz;
  assign bus.dataValid = (state == WR_DATA) ? 1'b1 : 1'bz;
endmodule

// File: tb/tb_simplebus_leader_engine.sv
// tb_simplebus_leader_engine: drives host commands against a behavioural memory
// follower and scores bus activity and responses against a cycle-level model.
module tb_simplebus_leader_engine;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;
  localparam int NEVER      = 1000;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;

  simplebus bus_if ();

  simplebus_leader_engine #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .resetN    (resetN),
    .bus       (bus_if),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // One entry per accepted command: push cycle p, start cycle s, response cycle r.
  typedef struct {
    bit        write;
    bit [15:0] addr;
    bit [7:0]  wdata;
    int        p;
    int        s;
    int        r;
    bit [7:0]  exp_rdata;
    bit        exp_err;
  } cmd_t;

  cmd_t     cmds[$];
  int       rsp_idx = 0;
  int       fol_delays[$];
  bit [7:0] model_mem [bit [15:0]];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit model_ready(input int c);
    int occ;
    occ = 0;
    foreach (cmds[i]) begin
      if (cmds[i].p < c) occ++;
      if (cmds[i].s < c) occ--;
    end
    return occ < FIFO_DEPTH;
  endfunction

  // Follower: memory target with a per-read response delay (>= TIMEOUT means silent).
  logic           fol_drive = 1'b0;
  logic [7:0]     fol_data = '0;
  logic [7:0]     fol_hi = '0;
  logic [15:0]    fol_addr_q = '0;
  int             fol_phase = 0;
  int             fol_wait = 0;
  logic [7:0]     fol_mem [bit [15:0]];

  assign bus_if.data      = fol_drive ? fol_data : 8'bz;
  assign bus_if.dataValid = fol_drive ? 1'b1 : 1'bz;

  always @(posedge clock or negedge resetN) begin : follower
    logic [15:0] a;
    int          fd;
    if (!resetN) begin
      fol_drive <= 1'b0;
      fol_phase <= 0;
      fol_wait  <= 0;
    end else begin
      case (fol_phase)
        0: if (bus_if.start) begin
             fol_hi    <= bus_if.address;
             fol_phase <= 1;
           end
        1: begin
             a = {fol_hi, bus_if.address};
             fol_addr_q <= a;
             if (bus_if.read) begin
               if (fol_delays.size() > 0) fd = fol_delays.pop_front();
               else fd = NEVER;
               fol_data <= fol_mem.exists(a) ? fol_mem[a] : 8'h00;
               if (fd >= TIMEOUT) fol_phase <= 0;
               else if (fd == 0) begin
                 fol_drive <= 1'b1;
                 fol_phase <= 3;
               end else begin
                 fol_wait  <= fd;
                 fol_phase <= 2;
               end
             end else begin
               fol_phase <= 4;
             end
           end
        2: if (fol_wait == 1) begin
             fol_drive <= 1'b1;
             fol_phase <= 3;
           end else begin
             fol_wait <= fol_wait - 1;
           end
        3: begin
             fol_drive <= 1'b0;
             fol_phase <= 0;
           end
        4: begin
             if (bus_if.dataValid == 1'b1) fol_mem[fol_addr_q] = bus_if.data;
             fol_phase <= 0;
           end
        default: fol_phase <= 0;
      endcase
    end
  end

  // Per-cycle scoring of bus pins and responses against the command timeline.
  always @(negedge clock) begin : monitor
    logic [31:0] e_start, e_read, e_addr, e_wd;
    bit          addr_on, wr_on, exp_v;
    e_start = 0; e_read = 0; e_addr = 0; e_wd = 0;
    addr_on = 0; wr_on = 0;
    foreach (cmds[i]) begin
      if (cmds[i].s == cyc) begin
        e_start = 1;
        addr_on = 1;
        e_addr  = 32'(cmds[i].addr[15:8]);
      end
      if (cmds[i].s + 1 == cyc) begin
        addr_on = 1;
        e_addr  = 32'(cmds[i].addr[7:0]);
        e_read  = 32'(!cmds[i].write);
      end
      if (cmds[i].write && cmds[i].s + 2 == cyc) begin
        wr_on = 1;
        e_wd  = 32'(cmds[i].wdata);
      end
    end
    checkOutput("bus_start", 32'(bus_if.start), e_start);
    checkOutput("bus_read", 32'(bus_if.read), e_read);
    if (addr_on) checkOutput("bus_address", 32'(bus_if.address), e_addr);
    if (wr_on) begin
      checkOutput("bus_data", 32'(bus_if.data), e_wd);
      checkOutput("bus_dataValid", 32'(bus_if.dataValid), 32'd1);
    end
    exp_v = (rsp_idx < cmds.size()) && (cmds[rsp_idx].r == cyc);
    if (rsp_valid || exp_v) begin
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
        checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(cmds[rsp_idx].exp_rdata));
        checkOutput("rsp_err", 32'(rsp_err), 32'(cmds[rsp_idx].exp_err));
        rsp_idx++;
      end
    end
  end

  // Present one command, holding req_valid until the model says it is accepted.
  task automatic applyStimulus(input bit w, input logic [15:0] a, input logic [7:0] d,
                               input int delay);
    cmd_t c;
    int   waited;
    bit   mr;
    waited = 0;
    forever begin
      @(negedge clock);
      mr = model_ready(cyc);
      checkOutput("req_ready", 32'(req_ready), 32'(mr));
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      if (mr) begin
        c.write = w; c.addr = a; c.wdata = d; c.p = cyc; c.s = cyc + 1;
        if (cmds.size() > 0 && cmds[cmds.size()-1].r > c.s) c.s = cmds[cmds.size()-1].r;
        if (w) begin
          c.r = c.s + 3; c.exp_rdata = 8'h00; c.exp_err = 1'b0;
          model_mem[a] = d;
        end else if (delay >= TIMEOUT) begin
          c.r = c.s + 2 + TIMEOUT; c.exp_rdata = 8'h00; c.exp_err = 1'b1;
        end else begin
          c.r = c.s + 3 + delay; c.exp_err = 1'b0;
          c.exp_rdata = model_mem.exists(a) ? model_mem[a] : 8'h00;
        end
        cmds.push_back(c);
        if (!w) fol_delays.push_back(delay);
        @(posedge clock);
        #1 req_valid = 1'b0;
        break;
      end
      waited++;
      if (waited > 200) begin
        checkOutput("req_accept", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_idx < cmds.size() && n < 500) begin
      @(negedge clock); #1;
      n++;
    end
    checkOutput("drained", 32'(rsp_idx), 32'(cmds.size()));
  endtask

  initial begin
    int base, target, guard;
    bit w;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_start", 32'(bus_if.start), 32'd0);
    checkOutput("reset_read", 32'(bus_if.read), 32'd0);
    @(negedge clock) resetN = 1'b1;

    $display("[TB] write then read back 0x0406");
    applyStimulus(1'b1, 16'h0406, 8'hDC, 0);
    applyStimulus(1'b0, 16'h0406, 8'h00, 2);
    drain();

    $display("[TB] four back-to-back writes and read-back");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0010 + 16'(i), 8'hA0 + 8'(i), 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0010 + 16'(i), 8'h00, i);
    drain();

    $display("[TB] fill the FIFO behind a slow read");
    applyStimulus(1'b0, 16'h0010, 8'h00, 10);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h0020 + 16'(i), 8'hB0 + 8'(i), 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0020 + 16'(i), 8'h00, 0);
    drain();

    $display("[TB] silent follower timeout then normal write");
    applyStimulus(1'b0, 16'h1234, 8'h00, NEVER);
    applyStimulus(1'b1, 16'h1235, 8'h5A, 0);
    applyStimulus(1'b0, 16'h1235, 8'h00, 0);
    drain();

    $display("[TB] dataValid on the last allowed cycle");
    applyStimulus(1'b1, 16'h0777, 8'h3C, 0);
    applyStimulus(1'b0, 16'h0777, 8'h00, TIMEOUT - 1);
    drain();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 60; i++) begin
      w = ($urandom_range(0, 1) == 1);
      applyStimulus(w, {12'h300, 4'($urandom_range(0, 7))}, 8'($urandom),
                    ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, TIMEOUT - 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clock);
    end
    drain();

    $display("[TB] reset during RD_WAIT with commands queued");
    base = cmds.size();
    applyStimulus(1'b0, 16'h0200, 8'h00, NEVER);
    applyStimulus(1'b1, 16'h0201, 8'h11, 0);
    applyStimulus(1'b1, 16'h0202, 8'h22, 0);
    target = cmds[base].s + 5;
    guard = 0;
    while (cyc < target && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    @(posedge clock);
    #2 resetN = 1'b0;
    cmds.delete();
    rsp_idx = 0;
    fol_delays.delete();
    #1;
    checkOutput("async_reset_start", 32'(bus_if.start), 32'd0);
    checkOutput("async_reset_read", 32'(bus_if.read), 32'd0);
    checkOutput("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("async_reset_req_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock); #1;
    checkOutput("post_reset_req_ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clock);
    applyStimulus(1'b1, 16'h0300, 8'h77, 0);
    applyStimulus(1'b0, 16'h0300, 8'h00, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
